// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix frame scheduler.
//   state_t    : scheduler FSM states (IDLE, GAP, RUN)
//   GS_DEFAULT : default grid size (8x8 matrix)
//   FRAME_W    : flat frame width for the default grid size
//   row_lsb()  : LSB position of row r inside a flat frame
package matrix_pkg;

  localparam int GS_DEFAULT = 8;
  localparam int FRAME_W    = GS_DEFAULT * GS_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Row r occupies bits [r*gs +: gs] of a flat frame.
  function automatic int row_lsb(input int row, input int gs);
    return row * gs;
  endfunction

endpackage

// File: rtl/matrix_back_buffer.sv
// GS x GS back buffer, written one full row at a time.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   wr_en_i         : write one row this cycle
//   wr_row_i        : row index; rows >= GS are ignored
//   wr_data_i       : replacement pixels for that row
//   frame_o         : registered back-buffer contents
//   frame_merged_o  : frame_o with this cycle's write already applied
module matrix_back_buffer
  import matrix_pkg::*;
#(
  parameter int GS = GS_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [$clog2(GS)-1:0] wr_row_i,
  input  logic [GS-1:0]         wr_data_i,
  output logic [GS*GS-1:0]      frame_o,
  output logic [GS*GS-1:0]      frame_merged_o
);

  logic [GS*GS-1:0] frame_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    frame_merged_o = frame_q;
    if (wr_en_i && (int'(wr_row_i) < GS)) begin
      frame_merged_o[row_lsb(int'(wr_row_i), GS) +: GS] = wr_data_i;
    end
  end

  // NOTE: this register file is reset because the displayed frame must start blank; storage that
  // is always written before being read would not need it.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_merged_o;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/matrix_frame_sched.sv
// Frame scheduler and double buffer for the LED matrix scanner.
// Runs the display enable/done handshake and swaps the back buffer into the
// displayed frame only in the one-cycle GAP between scans.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   enable_i       : scanning runs while high
//   wr_en_i/wr_row_i/wr_data_i : back-buffer row write
//   commit_i       : request a back-to-front swap
//   commit_ack_o   : one-cycle pulse when matrix_o takes a new frame
//   d_disp_i       : scan done from the display
//   e_disp_o       : scan enable to the display
//   matrix_o       : displayed frame
//   busy_o         : FSM not in IDLE
//   frame_cnt_o    : completed swaps, wraps at 256
//   err_o          : sticky scan-timeout flag
module matrix_frame_sched
  import matrix_pkg::*;
#(
  parameter int GS  = GS_DEFAULT,
  parameter int TMO = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  wr_en_i,
  input  logic [$clog2(GS)-1:0] wr_row_i,
  input  logic [GS-1:0]         wr_data_i,
  input  logic                  commit_i,
  output logic                  commit_ack_o,
  input  logic                  d_disp_i,
  output logic                  e_disp_o,
  output logic [GS*GS-1:0]      matrix_o,
  output logic                  busy_o,
  output logic [7:0]            frame_cnt_o,
  output logic                  err_o
);

  localparam int             CW       = $clog2(TMO);
  localparam logic [CW-1:0]  TMO_LAST = CW'(TMO - 1);

  state_t           state_q, state_nx;
  logic             en_q, done_q;
  logic             pending_q;
  logic             timeout;
  logic             swap;
  logic [CW-1:0]    tmo_cnt_q;
  logic [GS*GS-1:0] back_frame, merged_frame, swap_frame;

  matrix_back_buffer #(.GS(GS)) u_back (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_en_i        (wr_en_i),
    .wr_row_i       (wr_row_i),
    .wr_data_i      (wr_data_i),
    .frame_o        (back_frame),
    .frame_merged_o (merged_frame)
  );

  // A row landing in the GAP cycle is part of the swapped frame.
  assign swap_frame = wr_en_i ? merged_frame : back_frame;
  assign swap       = (state_q == GAP) && (pending_q || commit_i);

  // enable_i and d_disp_i are registered before the FSM acts on them, which
  // places GAP one cycle after the sampling edge and keeps e_disp_o glitch-free.
  always_comb begin
    state_nx = state_q;
    timeout  = 1'b0;
    case (state_q)
      IDLE: if (en_q) state_nx = GAP;
      GAP:  state_nx = en_q ? RUN : IDLE;
      RUN: begin
        // Dropping enable does not abort a scan; exit happens via GAP.
        if (done_q) begin
          state_nx = GAP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_nx = GAP;
          timeout  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_nx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      e_disp_o     <= 1'b0;
      busy_o       <= 1'b0;
      tmo_cnt_q    <= '0;
      err_o        <= 1'b0;
      commit_ack_o <= 1'b0;
      matrix_o     <= '0;
      frame_cnt_o  <= '0;
      pending_q    <= 1'b0;
    end else begin
      en_q         <= enable_i;
      done_q       <= d_disp_i;
      e_disp_o     <= (state_nx == RUN);
      busy_o       <= (state_nx != IDLE);
      tmo_cnt_q    <= (state_q == RUN && state_nx == RUN) ? tmo_cnt_q + 1'b1 : '0;
      err_o        <= err_o | timeout;
      commit_ack_o <= swap;
      if (swap) begin
        matrix_o    <= swap_frame;
        frame_cnt_o <= frame_cnt_o + 8'd1;
      end
      // A commit arriving in the swap cycle is absorbed by that swap.
      pending_q <= swap ? 1'b0 : (pending_q | commit_i);
    end
  end

endmodule

// File: tb/tb_matrix_frame_sched.sv
module tb_matrix_frame_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, wr_en, commit, d_disp;
  logic [2:0]  wr_row;
  logic [7:0]  wr_data;
  logic        ack, e_disp, busy, err;
  logic [63:0] matrix;
  logic [7:0]  frame_cnt;

  // Second instance with a short timeout; the display never answers it.
  logic        enable2, commit2;
  logic        d_disp2  = 1'b0;
  logic        wr_en2   = 1'b0;
  logic [2:0]  wr_row2  = 3'd0;
  logic [7:0]  wr_data2 = 8'd0;
  logic        ack2, e_disp2, busy2, err2;
  logic [63:0] matrix2;
  logic [7:0]  frame_cnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  matrix_frame_sched dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .wr_en_i(wr_en),
    .wr_row_i(wr_row), .wr_data_i(wr_data), .commit_i(commit),
    .commit_ack_o(ack), .d_disp_i(d_disp), .e_disp_o(e_disp),
    .matrix_o(matrix), .busy_o(busy), .frame_cnt_o(frame_cnt), .err_o(err)
  );

  matrix_frame_sched #(.GS(8), .TMO(16)) dut_tmo (
    .clk_i(clk), .rst_i(rst), .enable_i(enable2), .wr_en_i(wr_en2),
    .wr_row_i(wr_row2), .wr_data_i(wr_data2), .commit_i(commit2),
    .commit_ack_o(ack2), .d_disp_i(d_disp2), .e_disp_o(e_disp2),
    .matrix_o(matrix2), .busy_o(busy2), .frame_cnt_o(frame_cnt2), .err_o(err2)
  );

  // Advance one edge; inputs driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Display reports done (sampled at edge n); returns in the GAP cycle after edge n+1.
  task automatic end_scan();
    d_disp = 1'b1;
    tick();
    d_disp = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (e_disp !== 1'b0) begin n_fail++; $display("FAIL rst_e_disp: got %b want 0", e_disp); end
      n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
      n_cmp++; if (matrix !== 64'h0) begin n_fail++; $display("FAIL rst_matrix: got %h want 0", matrix); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    end
    rst    = 1'b0;
    enable = 1'b1;
    tick();  // edge k samples enable
    n_cmp++; if ({busy, e_disp} !== 2'b00) begin n_fail++; $display("FAIL en_k: got busy/e_disp %b want 00", {busy, e_disp}); end
    tick();  // k+1: GAP
    n_cmp++; if ({busy, e_disp} !== 2'b10) begin n_fail++; $display("FAIL en_k1_gap: got busy/e_disp %b want 10", {busy, e_disp}); end
    tick();  // k+2: RUN
    n_cmp++; if (e_disp !== 1'b1) begin n_fail++; $display("FAIL en_k2_e_disp: got %b want 1", e_disp); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL en_no_ack: got %b want 0", ack); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL en_frame_cnt: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_write_commit();
    for (int r = 0; r < 8; r++) begin
      wr_en   = 1'b1;
      wr_row  = 3'(r);
      wr_data = 8'h01 << r;
      commit  = (r == 4);
      tick();
    end
    wr_en  = 1'b0;
    commit = 1'b0;
    n_cmp++; if (matrix !== 64'h0) begin n_fail++; $display("FAIL wc_front_untouched: got %h want 0", matrix); end
    wait_cycles(11);
    d_disp = 1'b1;
    tick();  // edge n
    d_disp = 1'b0;
    n_cmp++; if (e_disp !== 1'b1) begin n_fail++; $display("FAIL wc_e_disp_n: got %b want 1", e_disp); end
    tick();  // n+1: GAP
    n_cmp++; if (e_disp !== 1'b0) begin n_fail++; $display("FAIL wc_e_disp_gap: got %b want 0", e_disp); end
    n_cmp++; if (matrix !== 64'h0) begin n_fail++; $display("FAIL wc_matrix_n1: got %h want 0", matrix); end
    tick();  // n+2: swap visible
    n_cmp++; if (matrix !== 64'h8040201008040201) begin n_fail++; $display("FAIL wc_matrix: got %h want 8040201008040201", matrix); end
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wc_ack: got %b want 1", ack); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL wc_frame_cnt: got %0d want 1", frame_cnt); end
    n_cmp++; if (e_disp !== 1'b1) begin n_fail++; $display("FAIL wc_e_disp_n2: got %b want 1", e_disp); end
    tick();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wc_ack_one_cycle: got %b want 0", ack); end
  endtask

  task automatic test_gap_write();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_cycles(5);
    end_scan();
    n_cmp++; if ({busy, e_disp} !== 2'b10) begin n_fail++; $display("FAIL gw_gap_state: got busy/e_disp %b want 10", {busy, e_disp}); end
    wr_en   = 1'b1;
    wr_row  = 3'd3;
    wr_data = 8'hFF;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (matrix !== 64'h80402010FF040201) begin n_fail++; $display("FAIL gw_matrix: got %h want 80402010ff040201", matrix); end
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL gw_ack: got %b want 1", ack); end
    n_cmp++; if (frame_cnt !== 8'd2) begin n_fail++; $display("FAIL gw_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_multi_commit();
    int acks;
    acks    = 0;
    wr_en   = 1'b1;
    wr_row  = 3'd0;
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
    end
    wait_cycles(4);
    end_scan();
    tick();
    n_cmp++; if (matrix !== 64'h80402010FF0402AA) begin n_fail++; $display("FAIL mc_matrix: got %h want 80402010ff0402aa", matrix); end
    n_cmp++; if (frame_cnt !== 8'd3) begin n_fail++; $display("FAIL mc_frame_cnt: got %0d want 3", frame_cnt); end
    if (ack === 1'b1) acks++;
    // Run one more scan with no commit and count any further acks.
    wait_cycles(5);
    d_disp = 1'b1;
    tick();
    d_disp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack === 1'b1) acks++;
    end
    n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL mc_ack_count: got %0d want 1", acks); end
    n_cmp++; if (frame_cnt !== 8'd3) begin n_fail++; $display("FAIL mc_frame_cnt_after: got %0d want 3", frame_cnt); end
  endtask

  // Commit that first appears in the GAP cycle: swapped at once and not re-pended.
  task automatic test_gap_commit();
    wait_cycles(5);
    end_scan();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL gc_ack: got %b want 1", ack); end
    n_cmp++; if (frame_cnt !== 8'd4) begin n_fail++; $display("FAIL gc_frame_cnt: got %0d want 4", frame_cnt); end
    wait_cycles(5);
    end_scan();
    tick();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL gc_no_repend: got %b want 0", ack); end
    n_cmp++; if (frame_cnt !== 8'd4) begin n_fail++; $display("FAIL gc_frame_cnt_after: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_disable_midscan();
    enable = 1'b0;
    wait_cycles(3);
    n_cmp++; if ({busy, e_disp} !== 2'b11) begin n_fail++; $display("FAIL dis_scan_continues: got busy/e_disp %b want 11", {busy, e_disp}); end
    end_scan();
    n_cmp++; if ({busy, e_disp} !== 2'b10) begin n_fail++; $display("FAIL dis_gap: got busy/e_disp %b want 10", {busy, e_disp}); end
    tick();
    n_cmp++; if ({busy, e_disp} !== 2'b00) begin n_fail++; $display("FAIL dis_idle: got busy/e_disp %b want 00", {busy, e_disp}); end
    wait_cycles(4);
    n_cmp++; if ({busy, e_disp} !== 2'b00) begin n_fail++; $display("FAIL dis_stays_idle: got busy/e_disp %b want 00", {busy, e_disp}); end
  endtask

  task automatic test_timeout();
    int high;
    int acks;
    enable2 = 1'b1;
    commit2 = 1'b0;
    wait_cycles(3);  // k, k+1 (GAP), k+2 (RUN)
    n_cmp++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL to_err_before: got %b want 0", err2); end
    high = (e_disp2 === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (e_disp2 !== 1'b1) break;
      high++;
    end
    n_cmp++; if (high !== 16) begin n_fail++; $display("FAIL to_run_cycles: got %0d want 16", high); end
    n_cmp++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b want 1", err2); end
    n_cmp++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL to_gap_busy: got %b want 1", busy2); end
    // Level commit: every GAP swaps. 256 swaps wrap the counter.
    commit2 = 1'b1;
    acks    = 0;
    for (int i = 0; i < 256 * 17 + 40; i++) begin
      tick();
      if (ack2 === 1'b1) begin
        acks++;
        if (acks == 255) begin
          n_cmp++; if (frame_cnt2 !== 8'd255) begin n_fail++; $display("FAIL to_cnt_255: got %0d want 255", frame_cnt2); end
        end
        if (acks == 256) break;
      end
    end
    n_cmp++; if (acks !== 256) begin n_fail++; $display("FAIL to_swap_count: got %0d want 256 (cycle bound)", acks); end
    n_cmp++; if (frame_cnt2 !== 8'd0) begin n_fail++; $display("FAIL to_cnt_wrap: got %0d want 0", frame_cnt2); end
    n_cmp++; if (err2 !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", err2); end
    commit2 = 1'b0;
    enable2 = 1'b0;
    wait_cycles(40);
    n_cmp++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL to_drain_idle: got %b want 0", busy2); end
  endtask

  task automatic test_reset_midscan();
    enable = 1'b1;
    wait_cycles(3);
    n_cmp++; if (e_disp !== 1'b1) begin n_fail++; $display("FAIL rm_running: got %b want 1", e_disp); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++; if ({busy, e_disp} !== 2'b00) begin n_fail++; $display("FAIL rm_drop: got busy/e_disp %b want 00", {busy, e_disp}); end
    n_cmp++; if (matrix !== 64'h0) begin n_fail++; $display("FAIL rm_matrix: got %h want 0", matrix); end
    n_cmp++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL rm_err_cleared: got %b want 0", err2); end
    rst = 1'b0;
    wait_cycles(3);
    n_cmp++; if (e_disp !== 1'b1) begin n_fail++; $display("FAIL rm_restart: got %b want 1", e_disp); end
    wait_cycles(3);
    end_scan();
    tick();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rm_pending_lost: got %b want 0", ack); end
    // Back buffer was cleared too: the next swap shows a blank frame.
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wait_cycles(3);
    end_scan();
    tick();
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rm_ack: got %b want 1", ack); end
    n_cmp++; if (matrix !== 64'h0) begin n_fail++; $display("FAIL rm_blank_frame: got %h want 0", matrix); end
    n_cmp++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL rm_frame_cnt_after: got %0d want 1", frame_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rm_no_err: got %b want 0", err); end
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    wr_en   = 1'b0;
    wr_row  = 3'd0;
    wr_data = 8'd0;
    commit  = 1'b0;
    d_disp  = 1'b0;
    enable2 = 1'b0;
    commit2 = 1'b0;
    test_reset();
    test_write_commit();
    test_gap_write();
    test_multi_commit();
    test_gap_commit();
    test_disable_midscan();
    test_timeout();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
